hdmi_frame_dma_ctrl: RTL and testbench

Frame-write DMA controller between the HDMI receiver's Avalon-ST output and an Avalon-MM memory write port. It takes the start address, word count and enable written through the receiver's control registers, aligns to frame start, and writes one frame per enable cycle as single-word writes at consecutive word addresses. It also reports frame completion and sticky framing errors back to the register file.

---
 rtl/hdmi_frame_dma_ctrl.sv | 174 +++++++++++++++++
 tb/tb_hdmi_frame_dma_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_frame_dma_ctrl.sv
// Frame-write DMA: aligns the HDMI Avalon-ST stream to SOP and writes one frame per enable as single words.
// One-deep output register, beat accepted in N -> write in N+1; st_ready drops while a write stalls.
module hdmi_frame_dma_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [29:0]           words_number,
  input  logic                  dma_enable,
  input  logic                  err_clear,
  input  logic [31:0]           st_data,
  input  logic                  st_valid,
  input  logic                  st_startofpacket,
  input  logic                  st_endofpacket,
  output logic                  st_ready,
  output logic [ADDR_WIDTH-1:0] avl_mm_address,
  output logic                  avl_mm_write,
  output logic [31:0]           avl_mm_writedata,
  output logic [3:0]            avl_mm_byteenable,
  input  logic                  avl_mm_waitrequest,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  err_sync
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_SOP, S_XFER, S_DROP, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base, addr_nxt;
  logic [29:0]           cnt, idx, eff_idx, idx_nxt;
  logic                  ending, ending_nxt, eop_seen, eop_seen_nxt;
  logic                  rdy, acc, wr_acc, drained, beat;
  logic                  load, latch_cfg, set_short, set_long, set_sync;

  assign acc     = st_valid & st_ready;
  assign wr_acc  = avl_mm_write & ~avl_mm_waitrequest;
  assign drained = ~avl_mm_write | wr_acc;

  assign avl_mm_byteenable = 4'hF;
  assign busy              = (state != S_IDLE);
  assign frame_done        = (state == S_DONE);

  always_comb begin
    rdy = 1'b0;
    case (state)
      S_IDLE, S_WAIT_SOP, S_DROP: rdy = 1'b1;
      // ending: hold the stream until the last write leaves the output register
      S_XFER:  rdy = ~ending & (~avl_mm_write | ~avl_mm_waitrequest);
      default: rdy = 1'b0;
    endcase
  end

  assign st_ready = rdy & ~rst_sys;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    load         = 1'b0;
    latch_cfg    = 1'b0;
    set_short    = 1'b0;
    set_long     = 1'b0;
    set_sync     = 1'b0;
    beat         = 1'b0;
    ending_nxt   = ending;
    eop_seen_nxt = eop_seen;
    eff_idx      = st_startofpacket ? '0 : idx;
    idx_nxt      = eff_idx + 30'd1;
    addr_nxt     = base + ADDR_WIDTH'({eff_idx, 2'b00});
    case (state)
      S_IDLE: begin
        if (dma_enable) begin
          latch_cfg = 1'b1;
          state_nxt = S_WAIT_SOP;
        end
      end
      S_WAIT_SOP: begin
        if (acc && st_startofpacket) begin
          if (cnt == '0) begin
            state_nxt    = S_DROP;
            eop_seen_nxt = st_endofpacket;
          end else begin
            state_nxt = S_XFER;
            beat      = 1'b1;
          end
        end
      end
      S_XFER: begin
        if (ending) begin
          if (drained) begin
            ending_nxt = 1'b0;
            state_nxt  = S_DONE;
          end
        end else if (acc) begin
          beat     = 1'b1;
          set_sync = st_startofpacket;
        end
      end
      S_DROP: begin
        if (acc && st_endofpacket) eop_seen_nxt = 1'b1;
        if ((eop_seen || (acc && st_endofpacket)) && drained) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (dma_enable) begin
          latch_cfg = 1'b1;
          state_nxt = S_WAIT_SOP;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // shared end-of-frame decision for the first beat and every later data beat
    if (beat) begin
      load = 1'b1;
      if (st_endofpacket && (idx_nxt < cnt)) begin
        set_short  = 1'b1;
        ending_nxt = 1'b1;
      end else if (idx_nxt == cnt) begin
        if (st_endofpacket) begin
          ending_nxt = 1'b1;
        end else begin
          set_long     = 1'b1;
          eop_seen_nxt = 1'b0;
          state_nxt    = S_DROP;
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      base             <= '0;
      cnt              <= '0;
      idx              <= '0;
      ending           <= 1'b0;
      eop_seen         <= 1'b0;
      avl_mm_write     <= 1'b0;
      avl_mm_address   <= '0;
      avl_mm_writedata <= '0;
      frame_count      <= '0;
      err_short        <= 1'b0;
      err_long         <= 1'b0;
      err_sync         <= 1'b0;
    end else begin
      if (latch_cfg) begin
        base <= start_addr & ~ADDR_WIDTH'(3);
        cnt  <= words_number;
      end
      if (load) begin
        avl_mm_write     <= 1'b1;
        avl_mm_address   <= addr_nxt;
        avl_mm_writedata <= st_data;
        idx              <= idx_nxt;
      end else if (wr_acc) begin
        avl_mm_write <= 1'b0;
      end
      ending   <= ending_nxt;
      eop_seen <= eop_seen_nxt;
      if (state == S_DONE) frame_count <= frame_count + 16'd1;
      err_short <= (err_short & ~err_clear) | set_short;
      err_long  <= (err_long  & ~err_clear) | set_long;
      err_sync  <= (err_sync  & ~err_clear) | set_sync;
    end
  end

endmodule

// File: tb/tb_hdmi_frame_dma_ctrl.sv
// Scoreboard bench for hdmi_frame_dma_ctrl: stimulus pushes expected writes/frame records, a monitor pops them.
module tb_hdmi_frame_dma_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst_sys;
  logic [31:0] start_addr;
  logic [29:0] words_number;
  logic        dma_enable, err_clear;
  logic [31:0] st_data;
  logic        st_valid, st_startofpacket, st_endofpacket, st_ready;
  logic [31:0] avl_mm_address, avl_mm_writedata;
  logic        avl_mm_write, avl_mm_waitrequest;
  logic [3:0]  avl_mm_byteenable;
  logic        busy, frame_done, err_short, err_long, err_sync;
  logic [15:0] frame_count;

  hdmi_frame_dma_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .start_addr(start_addr), .words_number(words_number),
    .dma_enable(dma_enable), .err_clear(err_clear), .st_data(st_data), .st_valid(st_valid),
    .st_startofpacket(st_startofpacket), .st_endofpacket(st_endofpacket), .st_ready(st_ready),
    .avl_mm_address(avl_mm_address), .avl_mm_write(avl_mm_write), .avl_mm_writedata(avl_mm_writedata),
    .avl_mm_byteenable(avl_mm_byteenable), .avl_mm_waitrequest(avl_mm_waitrequest), .busy(busy),
    .frame_done(frame_done), .frame_count(frame_count), .err_short(err_short), .err_long(err_long),
    .err_sync(err_sync));

  always #5 clk_sys = ~clk_sys;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [15:0] fc; logic [2:0] e; } fd_t;

  wr_t exp_wr[$];
  fd_t exp_fd[$];
  int  n_chk = 0, n_fail = 0, nwr = 0;
  logic [15:0] m_fc = '0;
  logic [2:0]  m_err = '0;   // {short, long, sync}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: a write presented with waitrequest low is taken on the coming edge
  always @(negedge clk_sys) begin
    if (!rst_sys) begin
      if (avl_mm_write && !avl_mm_waitrequest) begin
        if (exp_wr.size() == 0) chk("unexpected_write", avl_mm_address, 32'hxxxx_xxxx);
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          chk("wr_addr", avl_mm_address, w.a);
          chk("wr_data", avl_mm_writedata, w.d);
          chk("wr_be", {28'd0, avl_mm_byteenable}, 32'hF);
          nwr++;
        end
      end
      if (frame_done) begin
        if (exp_fd.size() == 0) chk("unexpected_frame_done", {31'd0, frame_done}, 32'd0);
        else begin
          fd_t f;
          f = exp_fd.pop_front();
          chk("fd_count", {16'd0, frame_count}, {16'd0, f.fc});
          chk("fd_errs", {29'd0, err_short, err_long, err_sync}, {29'd0, f.e});
          chk("fd_writes_left", exp_wr.size(), 0);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic sop, input logic eop);
    logic a;
    int t;
    a = 1'b0;
    t = 0;
    st_valid = 1'b1; st_data = d; st_startofpacket = sop; st_endofpacket = eop;
    while (!a && t < 200) begin
      @(negedge clk_sys);
      a = st_ready;
      @(posedge clk_sys); #1;
      t++;
    end
    chk("send_accept", {31'd0, a}, 32'd1);
    st_valid = 1'b0; st_startofpacket = 1'b0; st_endofpacket = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 50) begin
      @(posedge clk_sys); #1;
      t++;
    end
    chk("back_to_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic enable_cfg(input logic [31:0] base, input logic [29:0] cnt);
    start_addr = base; words_number = cnt; dma_enable = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic push_frame(input logic [2:0] set_err);
    m_err = m_err | set_err;
    exp_fd.push_back('{fc: m_fc, e: m_err});
    m_fc++;
  endtask

  // one frame of nb beats; dma_enable dropped after the first beat
  task automatic frame(input logic [31:0] base, input logic [29:0] cnt, input int nb, input logic [31:0] seed);
    enable_cfg(base, cnt);
    for (int i = 0; i < nb && i < int'(cnt); i++) exp_wr.push_back('{a: base + 32'(4 * i), d: seed + 32'(i)});
    push_frame({nb < int'(cnt), nb > int'(cnt), 1'b0});
    for (int i = 0; i < nb; i++) begin
      send(seed + 32'(i), i == 0, i == nb - 1);
      if (i == 0) dma_enable = 1'b0;
    end
    @(negedge clk_sys);
    if (nb > int'(cnt)) chk("fd_after_eop", {31'd0, frame_done}, 32'd1);
    else begin
      chk("fd_not_early", {31'd0, frame_done}, 32'd0);
      @(negedge clk_sys);
      chk("fd_after_drain", {31'd0, frame_done}, 32'd1);
    end
    @(posedge clk_sys); #1;
    wait_idle();
  endtask

  task automatic check_reset();
    chk("rst_st_ready", {31'd0, st_ready}, 32'd0);
    chk("rst_write", {31'd0, avl_mm_write}, 32'd0);
    chk("rst_addr", avl_mm_address, 32'd0);
    chk("rst_data", avl_mm_writedata, 32'd0);
    chk("rst_be", {28'd0, avl_mm_byteenable}, 32'hF);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_errs", {29'd0, err_short, err_long, err_sync}, 32'd0);
  endtask

  initial begin
    int n0, t;
    logic [31:0] b;
    rst_sys = 1'b1; start_addr = '0; words_number = '0; dma_enable = 1'b0; err_clear = 1'b0;
    st_data = '0; st_valid = 1'b0; st_startofpacket = 1'b0; st_endofpacket = 1'b0;
    avl_mm_waitrequest = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_reset();
    rst_sys = 1'b0;
    @(negedge clk_sys);
    chk("ready_after_reset", {31'd0, st_ready}, 32'd1);
    @(posedge clk_sys); #1;

    // basic 4-word frame
    frame(32'h1000_0000, 30'd4, 4, 32'hA000_0000);
    chk("count_after_1", {16'd0, frame_count}, 32'd1);

    // stall on the second write for 3 cycles
    n0 = nwr;
    fork
      frame(32'h1000_0000, 30'd4, 4, 32'hB000_0000);
      begin
        t = 0;
        while (!(avl_mm_write && nwr == n0 + 1) && t < 100) begin
          @(posedge clk_sys); #1;
          t++;
        end
        avl_mm_waitrequest = 1'b1;
        repeat (3) begin
          @(negedge clk_sys);
          chk("stall_ready", {31'd0, st_ready}, 32'd0);
          chk("stall_addr", avl_mm_address, 32'h1000_0004);
          chk("stall_data", avl_mm_writedata, 32'hB000_0001);
          @(posedge clk_sys); #1;
        end
        avl_mm_waitrequest = 1'b0;
      end
    join

    // long frame, then short frame, then clear
    frame(32'h1000_0000, 30'd4, 6, 32'hC000_0000);
    chk("err_long_set", {31'd0, err_long}, 32'd1);
    frame(32'h1000_0000, 30'd4, 2, 32'hD000_0000);
    chk("err_short_set", {31'd0, err_short}, 32'd1);
    err_clear = 1'b1;
    @(posedge clk_sys); #1;
    err_clear = 1'b0;
    m_err = '0;
    chk("err_cleared", {29'd0, err_short, err_long, err_sync}, 32'd0);

    // garbage before SOP, SOP again at the 2nd data beat
    b = 32'h2000_0000;
    enable_cfg(b, 30'd4);
    foreach (exp_wr[i]) chk("queue_empty_pre_sync", 1, 0);
    exp_wr.push_back('{a: b,      d: 32'hE0});
    exp_wr.push_back('{a: b + 4,  d: 32'hE1});
    exp_wr.push_back('{a: b,      d: 32'hE2});
    exp_wr.push_back('{a: b + 4,  d: 32'hE3});
    exp_wr.push_back('{a: b + 8,  d: 32'hE4});
    exp_wr.push_back('{a: b + 12, d: 32'hE5});
    push_frame(3'b001);
    for (int i = 0; i < 3; i++) send(32'hBAD0 + 32'(i), 1'b0, 1'b0);
    send(32'hE0, 1'b1, 1'b0);
    dma_enable = 1'b0;
    send(32'hE1, 1'b0, 1'b0);
    send(32'hE2, 1'b1, 1'b0);
    send(32'hE3, 1'b0, 1'b0);
    send(32'hE4, 1'b0, 1'b0);
    send(32'hE5, 1'b0, 1'b1);
    wait_idle();
    chk("err_sync_set", {31'd0, err_sync}, 32'd1);

    // address wrap
    frame(32'hFFFF_FFF8, 30'd4, 4, 32'hF000_0000);
    chk("count_after_6", {16'd0, frame_count}, 32'd6);

    // reset mid-frame with a write stalled in the output register
    enable_cfg(32'h3000_0000, 30'd8);
    exp_wr.push_back('{a: 32'h3000_0000, d: 32'h77});
    send(32'h77, 1'b1, 1'b0);
    send(32'h78, 1'b0, 1'b0);
    avl_mm_waitrequest = 1'b1;
    rst_sys = 1'b1;
    dma_enable = 1'b0;
    @(posedge clk_sys); #1;
    check_reset();
    m_fc = '0;
    m_err = '0;
    avl_mm_waitrequest = 1'b0;
    rst_sys = 1'b0;
    @(negedge clk_sys);
    chk("ready_after_mid_reset", {31'd0, st_ready}, 32'd1);
    repeat (4) @(posedge clk_sys);
    #1;
    chk("writes_outstanding", exp_wr.size(), 0);
    chk("frames_outstanding", exp_fd.size(), 0);
    chk("count_final", {16'd0, frame_count}, {16'd0, m_fc});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
